// File: rtl/uart_rx_ctrl.sv
`timescale 1ns/1ps
// uart_rx_ctrl: UART receive engine with 3-sample majority voting,
// LSB-first deserializer and parity/start/stop checking.
// Ports:
//   clk, rst_n (async, active-low) : oversampling clock and reset
//   rx_in                          : synchronised serial line, idle high
//   prescale                       : oversampling ratio P (even, min 4)
//   par_en, par_typ, stp2_en       : frame format, latched at start
//   p_data, data_valid             : last good payload and its pulse
//   par_err, stp_err               : error pulses
//   brk_det                        : break pulse (UART_RX_BREAK_DET_EN)
//   busy                           : registered "not idle" flag
// Optional feature macro: UART_RX_BREAK_DET_EN.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  stp2_en,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  brk_det,
    output logic                  busy
);

    localparam int CW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef UART_RX_BREAK_DET_EN
        , S_BREAK
`endif
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [PRESCALE_W-1:0] w_pre_in;
    logic [PRESCALE_W-1:0] r_pre;
    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [PRESCALE_W-1:0] w_half;
    logic [CW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_p_data;

    logic r_par_en;
    logic r_par_typ;
    logic r_stp2;
    logic r_pfail;
    logic r_s0;
    logic r_s1;
    logic r_dv;
    logic r_pe;
    logic r_se;
    logic r_busy;

    logic w_vote;
    logic w_dec;
    logic w_wrap;
    logic w_at_s0;
    logic w_at_s1;
    logic w_exp_par;
    logic w_last_stop;
    logic w_start;
    logic w_dv_n;
    logic w_pe_n;
    logic w_se_n;
    logic w_shift;
    logic w_load;

`ifdef UART_RX_BREAK_DET_EN
    logic r_zero;
    logic r_brk;
    logic w_brk_n;
`endif

    // Bit 0 of prescale is ignored; ratios below 4 leave no room
    // for three samples before the wrap, so they are clamped.
    always_comb begin
        w_pre_in = prescale & ~PRESCALE_W'(1);
        if (w_pre_in < PRESCALE_W'(4)) begin
            w_pre_in = PRESCALE_W'(4);
        end
    end

    assign w_half      = r_pre >> 1;
    assign w_at_s0     = (r_edge_cnt == w_half - PRESCALE_W'(1));
    assign w_at_s1     = (r_edge_cnt == w_half);
    assign w_dec       = (r_edge_cnt == w_half + PRESCALE_W'(1));
    assign w_wrap      = (r_edge_cnt == r_pre - PRESCALE_W'(1));
    assign w_vote      = (r_s0 & r_s1) | (r_s0 & rx_in) | (r_s1 & rx_in);
    assign w_exp_par   = (^r_shift) ^ r_par_typ;
    assign w_last_stop = !r_stp2 || (r_bit_cnt == CW'(1));
    assign w_start     = (r_state == S_IDLE) && !rx_in;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and pulse decisions
    always_comb begin
        w_state_nxt = r_state;
        w_dv_n      = 1'b0;
        w_pe_n      = 1'b0;
        w_se_n      = 1'b0;
        w_shift     = 1'b0;
        w_load      = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        w_brk_n     = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (!rx_in) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                // With P=4 the decision and the wrap share a cycle.
                if (w_dec && w_vote) begin
                    w_state_nxt = S_IDLE;
                end else if (w_wrap) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_dec) begin
                    w_shift = 1'b1;
                end
                if (w_wrap && r_bit_cnt == CW'(DATA_WIDTH - 1)) begin
                    w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_dec && (w_vote != w_exp_par)) begin
                    w_pe_n = 1'b1;
                end
                if (w_wrap) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_dec) begin
                    if (!w_vote) begin
                        w_se_n      = 1'b1;
                        w_state_nxt = S_IDLE;
`ifdef UART_RX_BREAK_DET_EN
                        if (r_zero && r_bit_cnt == '0) begin
                            w_se_n      = 1'b0;
                            w_brk_n     = 1'b1;
                            w_state_nxt = S_BREAK;
                        end
`endif
                    end else if (w_last_stop) begin
                        // Leave early so a back-to-back start is seen.
                        w_state_nxt = S_IDLE;
                        w_dv_n      = !r_pfail;
                        w_load      = !r_pfail;
                    end
                end
            end
`ifdef UART_RX_BREAK_DET_EN
            S_BREAK: begin
                // Edge counter counts consecutive high samples here.
                if (rx_in && w_wrap) begin
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Counters, sampler, configuration latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_pre      <= PRESCALE_W'(4);
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_stp2     <= 1'b0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
        end else begin
            if (w_start) begin
                r_pre     <= w_pre_in;
                r_par_en  <= par_en;
                r_par_typ <= par_typ;
                r_stp2    <= stp2_en;
            end

            if (w_state_nxt == S_IDLE) begin
                r_edge_cnt <= '0;
            end else if (r_state == S_IDLE) begin
                // The detecting cycle itself counts as edge 0.
                r_edge_cnt <= PRESCALE_W'(1);
`ifdef UART_RX_BREAK_DET_EN
            end else if (w_state_nxt == S_BREAK) begin
                if (r_state == S_BREAK && rx_in) begin
                    r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
                end else begin
                    r_edge_cnt <= '0;
                end
`endif
            end else if (w_wrap) begin
                r_edge_cnt <= '0;
            end else begin
                r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
            end

            if (w_state_nxt != r_state) begin
                r_bit_cnt <= '0;
            end else if (w_wrap) begin
                r_bit_cnt <= r_bit_cnt + CW'(1);
            end

            if (r_state != S_IDLE) begin
                if (w_at_s0) begin
                    r_s0 <= rx_in;
                end
                if (w_at_s1) begin
                    r_s1 <= rx_in;
                end
            end
        end
    end

    // Deserializer, frame flags and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift  <= '0;
            r_p_data <= '0;
            r_pfail  <= 1'b0;
            r_dv     <= 1'b0;
            r_pe     <= 1'b0;
            r_se     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            if (w_shift) begin
                r_shift <= {w_vote, r_shift[DATA_WIDTH-1:1]};
            end
            if (w_start) begin
                r_pfail <= 1'b0;
            end else if (w_pe_n) begin
                r_pfail <= 1'b1;
            end
            if (w_load) begin
                r_p_data <= r_shift;
            end
            r_dv   <= w_dv_n;
            r_pe   <= w_pe_n;
            r_se   <= w_se_n;
            r_busy <= (r_state != S_IDLE);
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    // Tracks whether every bit voted so far in this frame was 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
            r_brk  <= 1'b0;
        end else begin
            if (w_start) begin
                r_zero <= 1'b1;
            end else if (w_dec && (r_state == S_START ||
                                   r_state == S_DATA ||
                                   r_state == S_PARITY)) begin
                r_zero <= r_zero & ~w_vote;
            end
            r_brk <= w_brk_n;
        end
    end

    assign brk_det = r_brk;
`else
    assign brk_det = 1'b0;
`endif

    assign p_data     = r_p_data;
    assign data_valid = r_dv;
    assign par_err    = r_pe;
    assign stp_err    = r_se;
    assign busy       = r_busy;

endmodule
